// File: rtl/game_board_renderer.sv
// game_board_renderer
// Graphic stage of the snake game. Maps the VGA pixel counters onto a grid of
// BLOCK_SIZE x BLOCK_SIZE blocks, classifies each block (head, tail, body,
// fruit, empty) and emits the 2-bit colour code read from the symbol ROM.
// Body coordinates are loaded into a double-buffered list; a row scanner
// pre-computes a ping-pong row mask one block row ahead of the beam.
//
// Ports:
//   clock_25, reset                 pixel clock, async active-high reset
//   X, Y                            screen pixel counters
//   snake_head_x/y, fruit_x/y       head and fruit block coordinates
//   snake_length                    body entries incl. tail (head excluded)
//   body_load/valid/x/y/commit      shadow-list load port, body_ready back
//   body_overflow                   sticky, more than LEN_MAX entries offered
//   selected_figure/selected_symbol symbol ROM address / data
//   game_area, game_enable, game_data  pixel outputs, 3 clocks after X/Y
//
// Optional: define GRID_BORDER_EN to draw a one-pixel ring around the grid.
module game_board_renderer #(
  parameter int unsigned BLOCK_SIZE = 5,
  parameter int unsigned GRID_W     = 124,
  parameter int unsigned GRID_H     = 81,
  parameter int unsigned X_OFF      = 58,
  parameter int unsigned Y_OFF      = 43,
  parameter int unsigned H_TOTAL    = 800,
  parameter int unsigned PIX_BITS   = 10,
  parameter int unsigned COORD_BITS = 7,
  parameter int unsigned LEN_MAX    = 64,
  parameter int unsigned LEN_BITS   = 7
) (
  input  logic                                  clock_25,
  input  logic                                  reset,
  input  logic [PIX_BITS-1:0]                   X,
  input  logic [PIX_BITS-1:0]                   Y,
  input  logic [COORD_BITS-1:0]                 snake_head_x,
  input  logic [COORD_BITS-1:0]                 snake_head_y,
  input  logic [COORD_BITS-1:0]                 fruit_x,
  input  logic [COORD_BITS-1:0]                 fruit_y,
  input  logic [LEN_BITS-1:0]                   snake_length,
  input  logic                                  body_load,
  input  logic                                  body_valid,
  output logic                                  body_ready,
  input  logic [COORD_BITS-1:0]                 body_x,
  input  logic [COORD_BITS-1:0]                 body_y,
  input  logic                                  body_commit,
  output logic                                  body_overflow,
  output logic [1:0]                            selected_figure,
  input  logic [2*BLOCK_SIZE*BLOCK_SIZE-1:0]    selected_symbol,
  output logic                                  game_area,
  output logic                                  game_enable,
  output logic [1:0]                            game_data
);

  localparam int unsigned SQ      = BLOCK_SIZE * BLOCK_SIZE;
  localparam int unsigned SYM_W   = 2 * SQ;
  localparam int unsigned X_END   = X_OFF + GRID_W * BLOCK_SIZE;
  localparam int unsigned Y_END   = Y_OFF + GRID_H * BLOCK_SIZE;
  localparam int unsigned SCAN_Y0 = Y_OFF - BLOCK_SIZE;
  localparam int unsigned LOC_W   = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int unsigned BIT_W   = $clog2(SYM_W);
  localparam int unsigned IDX_W   = (LEN_MAX > 1) ? $clog2(LEN_MAX) : 1;
  localparam int unsigned PTR_W   = $clog2(LEN_MAX + 1);

  localparam logic [1:0] FIG_HEAD   = 2'd0;
  localparam logic [1:0] FIG_BODY   = 2'd1;
  localparam logic [1:0] FIG_TAIL   = 2'd2;
  localparam logic [1:0] FIG_FRUIT  = 2'd3;
  localparam logic [1:0] CODE_BODY  = 2'd1;
  localparam logic [1:0] CODE_TAIL  = 2'd2;

  typedef enum logic [1:0] {
    SCAN_IDLE,
    SCAN_CLEAR,
    SCAN_WALK
  } scan_state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  scan_state_t                 scan_state, scan_nxt_c;
  logic [COORD_BITS-1:0]       scan_row;
  logic                        scan_bank;
  logic [LEN_BITS-1:0]         scan_idx;
  logic                        front_sel;
  logic [1:0]                  row_mask [2][GRID_W];

  logic                        act_bank;
  logic                        commit_pending;
  logic [LEN_BITS-1:0]         len_lat;
  logic [PTR_W-1:0]            wr_ptr;
  logic [COORD_BITS-1:0]       bank_x [2][LEN_MAX];
  logic [COORD_BITS-1:0]       bank_y [2][LEN_MAX];

  logic                        s1_area, s1_en, s1_border;
  logic [1:0]                  s1_fig;
  logic [LOC_W-1:0]            s1_xl, s1_yl;
  logic                        s2_area, s2_en, s2_border;
  logic [BIT_W-1:0]            s2_base;

  // ---------------------------------------------------------------------------
  // Pixel decode: block/local counters and line-level events
  // ---------------------------------------------------------------------------
  logic [PIX_BITS-1:0] x_rel_c, y_rel_c, ys_rel_c;
  logic [PIX_BITS-1:0] bx_c, by_c, xl_c, yl_c;
  logic                in_x_c, in_y_c, in_grid_c, border_c;
  logic                frame_start_c, row_swap_c, scan_start_c;
  logic [COORD_BITS-1:0] scan_row_c;

  always_comb begin
    x_rel_c   = X - PIX_BITS'(X_OFF);
    y_rel_c   = Y - PIX_BITS'(Y_OFF);
    ys_rel_c  = Y - PIX_BITS'(SCAN_Y0);
    bx_c      = x_rel_c / PIX_BITS'(BLOCK_SIZE);
    by_c      = y_rel_c / PIX_BITS'(BLOCK_SIZE);
    xl_c      = x_rel_c % PIX_BITS'(BLOCK_SIZE);
    yl_c      = y_rel_c % PIX_BITS'(BLOCK_SIZE);
    in_x_c    = (X >= PIX_BITS'(X_OFF)) && (X < PIX_BITS'(X_END));
    in_y_c    = (Y >= PIX_BITS'(Y_OFF)) && (Y < PIX_BITS'(Y_END));
    in_grid_c = in_x_c && in_y_c;
`ifdef GRID_BORDER_EN
    border_c  = !in_grid_c
              && (X >= PIX_BITS'(X_OFF - 1)) && (X <= PIX_BITS'(X_END))
              && (Y >= PIX_BITS'(Y_OFF - 1)) && (Y <= PIX_BITS'(Y_END));
`else
    border_c  = 1'b0;
`endif
    frame_start_c = (X == '0) && (Y == '0);
    // Front mask takes over on the first line of every block row.
    row_swap_c    = (X == '0) && in_y_c && (yl_c == '0);
    // Mask for row r is built during the first line of row r-1.
    scan_start_c  = (X == '0) && (Y >= PIX_BITS'(SCAN_Y0))
                  && (Y < PIX_BITS'(Y_END - BLOCK_SIZE))
                  && ((ys_rel_c % PIX_BITS'(BLOCK_SIZE)) == '0);
    scan_row_c    = COORD_BITS'(ys_rel_c / PIX_BITS'(BLOCK_SIZE));
  end

  // ---------------------------------------------------------------------------
  // Figure classification: head > tail > body > fruit > empty
  // ---------------------------------------------------------------------------
  logic [1:0] code_c, fig_c;
  logic       en_c, hit_head_c, hit_fruit_c;

  always_comb begin
    code_c      = 2'b00;
    fig_c       = FIG_HEAD;
    en_c        = 1'b0;
    hit_head_c  = (bx_c == PIX_BITS'(snake_head_x)) && (by_c == PIX_BITS'(snake_head_y));
    hit_fruit_c = (bx_c == PIX_BITS'(fruit_x)) && (by_c == PIX_BITS'(fruit_y));
    if (in_grid_c) begin
      code_c = row_mask[front_sel][COORD_BITS'(bx_c)];
      if (hit_head_c) begin
        fig_c = FIG_HEAD;
        en_c  = 1'b1;
      end else if (code_c == CODE_TAIL) begin
        fig_c = FIG_TAIL;
        en_c  = 1'b1;
      end else if (code_c == CODE_BODY) begin
        fig_c = FIG_BODY;
        en_c  = 1'b1;
      end else if (hit_fruit_c) begin
        fig_c = FIG_FRUIT;
        en_c  = 1'b1;
      end
    end
  end

  // Bit offset of the current pixel inside the symbol word; pixel 0 is the MSBs.
  int unsigned      pix_idx_c;
  logic [BIT_W-1:0] base_c;

  always_comb begin
    pix_idx_c = 32'(s1_yl) * BLOCK_SIZE + 32'(s1_xl);
    base_c    = BIT_W'(2 * (SQ - 1 - pix_idx_c));
  end

  // ---------------------------------------------------------------------------
  // Three-stage pixel pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      s1_area         <= 1'b0;
      s1_en           <= 1'b0;
      s1_border       <= 1'b0;
      s1_fig          <= 2'b00;
      s1_xl           <= '0;
      s1_yl           <= '0;
      s2_area         <= 1'b0;
      s2_en           <= 1'b0;
      s2_border       <= 1'b0;
      s2_base         <= '0;
      selected_figure <= 2'b00;
      game_area       <= 1'b0;
      game_enable     <= 1'b0;
      game_data       <= 2'b00;
    end else begin
      s1_area         <= in_grid_c;
      s1_en           <= en_c;
      s1_border       <= border_c;
      s1_fig          <= en_c ? fig_c : 2'b00;
      s1_xl           <= LOC_W'(xl_c);
      s1_yl           <= LOC_W'(yl_c);
      s2_area         <= s1_area;
      s2_en           <= s1_en;
      s2_border       <= s1_border;
      s2_base         <= base_c;
      selected_figure <= s1_fig;
      game_area       <= s2_area;
      game_enable     <= s2_en || s2_border;
      if (s2_en) begin
        game_data <= selected_symbol[s2_base +: 2];
      end else if (s2_border) begin
        game_data <= 2'b11;
      end else begin
        game_data <= 2'b00;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Row scanner FSM: clear back mask, then walk the active list
  // ---------------------------------------------------------------------------
  logic [COORD_BITS-1:0] ent_x_c, ent_y_c;
  logic                  ent_hit_c, ent_last_c, mask_clr_c, mask_wr_c, front_sel_nxt_c;

  always_comb begin
    ent_x_c    = bank_x[act_bank][IDX_W'(scan_idx)];
    ent_y_c    = bank_y[act_bank][IDX_W'(scan_idx)];
    ent_hit_c  = (ent_y_c == scan_row) && (32'(ent_x_c) < GRID_W);
    ent_last_c = (scan_idx == (len_lat - LEN_BITS'(1)));
    front_sel_nxt_c = row_swap_c ? ~front_sel : front_sel;
  end

  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      scan_state <= SCAN_IDLE;
    end else begin
      scan_state <= scan_nxt_c;
    end
  end

  always_comb begin
    scan_nxt_c = scan_state;
    mask_clr_c = 1'b0;
    mask_wr_c  = 1'b0;
    case (scan_state)
      SCAN_IDLE: ;
      SCAN_CLEAR: begin
        mask_clr_c = 1'b1;
        scan_nxt_c = (len_lat == '0) ? SCAN_IDLE : SCAN_WALK;
      end
      SCAN_WALK: begin
        mask_wr_c = ent_hit_c && !scan_start_c;
        if (ent_last_c) begin
          scan_nxt_c = SCAN_IDLE;
        end
      end
      default: scan_nxt_c = SCAN_IDLE;
    endcase
    if (scan_start_c) begin
      scan_nxt_c = SCAN_CLEAR;
    end
  end

  // Scanner datapath and ping-pong row masks.
  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      scan_row  <= '0;
      scan_bank <= 1'b0;
      scan_idx  <= '0;
      front_sel <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < int'(GRID_W); c++) begin
          row_mask[b][c] <= 2'b00;
        end
      end
    end else begin
      front_sel <= front_sel_nxt_c;
      if (scan_start_c) begin
        scan_row  <= scan_row_c;
        scan_bank <= ~front_sel_nxt_c;
        scan_idx  <= '0;
      end else if (scan_state == SCAN_WALK) begin
        scan_idx <= scan_idx + LEN_BITS'(1);
      end
      if (mask_clr_c) begin
        for (int c = 0; c < int'(GRID_W); c++) begin
          row_mask[scan_bank][c] <= 2'b00;
        end
      end else if (mask_wr_c) begin
        row_mask[scan_bank][ent_x_c] <= ent_last_c ? CODE_TAIL : CODE_BODY;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load port, commit handshake and frame-start bank swap
  // ---------------------------------------------------------------------------
  logic commit_nxt_c, swap_bank_c, accept_load_c, accept_wr_c, wr_room_c;

  always_comb begin
    commit_nxt_c  = commit_pending;
    swap_bank_c   = 1'b0;
    if (frame_start_c && commit_pending) begin
      swap_bank_c  = 1'b1;
      commit_nxt_c = 1'b0;
    end else if (body_commit) begin
      commit_nxt_c = 1'b1;
    end
    accept_load_c = body_load && !commit_pending;
    accept_wr_c   = body_valid && body_ready && !commit_pending && !accept_load_c;
    wr_room_c     = (wr_ptr < PTR_W'(LEN_MAX));
  end

  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      act_bank       <= 1'b0;
      commit_pending <= 1'b0;
      body_ready     <= 1'b1;
      len_lat        <= '0;
      wr_ptr         <= '0;
      body_overflow  <= 1'b0;
    end else begin
      commit_pending <= commit_nxt_c;
      body_ready     <= !commit_nxt_c;
      if (swap_bank_c) begin
        act_bank <= ~act_bank;
      end
      if (frame_start_c) begin
        len_lat <= (snake_length > LEN_BITS'(LEN_MAX)) ? LEN_BITS'(LEN_MAX) : snake_length;
      end
      if (accept_load_c) begin
        wr_ptr        <= '0;
        body_overflow <= 1'b0;
      end else if (accept_wr_c) begin
        if (wr_room_c) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end else begin
          body_overflow <= 1'b1;
        end
      end
    end
  end

  // Shadow list storage; contents need no reset.
  always_ff @(posedge clock_25) begin
    if (accept_wr_c && wr_room_c) begin
      bank_x[~act_bank][IDX_W'(wr_ptr)] <= body_x;
      bank_y[~act_bank][IDX_W'(wr_ptr)] <= body_y;
    end
  end

endmodule
